weight_buffer: RTL and testbench

Staging buffer directly upstream of `weight_counter` in the systolic-array weight path. Collects one full tile of weights (`ARRAY_SIZE` rows) from the host over a valid/ready interface, then pulses `trigger_weight` into `weight_counter`. While `weight_counter` holds `load` high, the buffer drains one row per cycle onto the array's weight shift-in bus. Fill and drain never overlap, so a tile is always presented to the array complete and in a fixed order.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/weight_row_mem.sv | 31 +++
 rtl/weight_buffer.sv | 110 +++++++++++
 tb/tb_weight_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | systolic_pkg : types and defaults shared by the weight path      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package systolic_pkg;

  localparam int ARRAY_SIZE_DEF = 4;
  localparam int DATA_W_DEF     = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRIG  = 2'd1,
    DRAIN = 2'd2
  } wbuf_state_t;

  typedef logic [ARRAY_SIZE_DEF-1:0][DATA_W_DEF-1:0] weight_row_t;

  // Pointer width able to hold every value 0..depth inclusive.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_row_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weight_row_mem : row register file, 1 sync write / 1 comb read   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module weight_row_mem #(
  parameter int DEPTH  = 4,
  parameter int ROW_W  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [ROW_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [ROW_W-1:0]  rdata_o
);

  // Storage is intentionally not reset; pointers alone define validity.
  logic [ROW_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/weight_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weight_buffer : stages one weight tile, then drains it on load   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module weight_buffer
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [ARRAY_SIZE*DATA_W-1:0] wdata_in,
  input  logic                         wvalid_in,
  output logic                         wready_out,
  output logic                         trigger_weight,
  input  logic                         load,
  output logic [ARRAY_SIZE*DATA_W-1:0] weight_out,
  output logic                         weight_valid_out,
  output logic                         load_err
);

  localparam int ROW_W  = ARRAY_SIZE * DATA_W;
  localparam int PTR_W  = ptr_width(ARRAY_SIZE);
  localparam int ADDR_W = $clog2(ARRAY_SIZE);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ARRAY_SIZE - 1);

  wbuf_state_t      state_q;
  logic [PTR_W-1:0] wr_cnt_q;
  logic [PTR_W-1:0] rd_cnt_q;
  logic             wready_q;
  logic             trigger_q;

  logic             handshake;
  logic             drain_fire;
  logic [ROW_W-1:0] rd_row;

  // wready_q is only ever high in FILL, so it doubles as the FILL qualifier.
  assign handshake  = wvalid_in && wready_q;
  assign drain_fire = load && (state_q == DRAIN);

  weight_row_mem #(
    .DEPTH  (ARRAY_SIZE),
    .ROW_W  (ROW_W),
    .ADDR_W (ADDR_W)
  ) u_row_mem (
    .clk     (clk),
    .we_i    (handshake),
    .waddr_i (wr_cnt_q[ADDR_W-1:0]),
    .wdata_i (wdata_in),
    .raddr_i (rd_cnt_q[ADDR_W-1:0]),
    .rdata_o (rd_row)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wready_q  <= 1'b1;
      trigger_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (handshake) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_PTR) begin
              state_q   <= TRIG;
              wready_q  <= 1'b0;
              trigger_q <= 1'b1;
            end
          end
        end
        TRIG: begin
          trigger_q <= 1'b0;
          rd_cnt_q  <= LAST_PTR;
          state_q   <= DRAIN;
        end
        DRAIN: begin
          if (load) begin
            rd_cnt_q <= rd_cnt_q - 1'b1;
            if (rd_cnt_q == '0) begin
              rd_cnt_q <= '0;
              wr_cnt_q <= '0;
              wready_q <= 1'b1;
              state_q  <= FILL;
            end
          end
        end
        default: begin
          state_q   <= FILL;
          wr_cnt_q  <= '0;
          rd_cnt_q  <= '0;
          wready_q  <= 1'b1;
          trigger_q <= 1'b0;
        end
      endcase
    end
  end

  assign wready_out       = wready_q;
  assign trigger_weight   = trigger_q;
  assign weight_valid_out = drain_fire;
  assign weight_out       = drain_fire ? rd_row : '0;
  // A load request with no tile staged is flagged but moves no data.
  assign load_err         = load && (state_q != DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_weight_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_weight_buffer : directed bench with a queue-based model       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_weight_buffer;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RW = N * DW;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [RW-1:0] wdata_in;
  logic          wvalid_in;
  logic          wready_out;
  logic          trigger_weight;
  logic          load;
  logic [RW-1:0] weight_out;
  logic          weight_valid_out;
  logic          load_err;

  always #5 clk = ~clk;

  weight_buffer #(.ARRAY_SIZE(N), .DATA_W(DW)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .wdata_in         (wdata_in),
    .wvalid_in        (wvalid_in),
    .wready_out       (wready_out),
    .trigger_weight   (trigger_weight),
    .load             (load),
    .weight_out       (weight_out),
    .weight_valid_out (weight_valid_out),
    .load_err         (load_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: tile as a queue, drain as a stack
  logic [RW-1:0] m_rows  [$];
  logic [RW-1:0] m_drain [$];
  bit            m_acc   = 1'b0;
  bit            m_trig  = 1'b0;
  bit            m_known = 1'b0;

  always @(negedge clk) begin
    bit            draining;
    bit            e_valid;
    logic [RW-1:0] e_out;
    if (m_known) begin
      draining = (m_drain.size() > 0);
      e_valid  = draining && load;
      e_out    = e_valid ? m_drain[0] : '0;
      chk("m_ready", 64'(wready_out),       64'(m_acc));
      chk("m_trig",  64'(trigger_weight),   64'(m_trig));
      chk("m_valid", 64'(weight_valid_out), 64'(e_valid));
      chk("m_out",   64'(weight_out),       64'(e_out));
      chk("m_err",   64'(load_err),         64'(!draining && load));
    end
    if (!n_rst) begin
      m_rows.delete();
      m_drain.delete();
      m_acc   = 1'b1;
      m_trig  = 1'b0;
      m_known = 1'b1;
    end else if (m_trig) begin
      m_trig = 1'b0;
      for (int i = m_rows.size() - 1; i >= 0; i--) m_drain.push_back(m_rows[i]);
      m_rows.delete();
    end else if (m_drain.size() > 0) begin
      if (load) begin
        void'(m_drain.pop_front());
        if (m_drain.size() == 0) m_acc = 1'b1;
      end
    end else if (m_acc && wvalid_in) begin
      m_rows.push_back(wdata_in);
      if (m_rows.size() == N) begin
        m_acc  = 1'b0;
        m_trig = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus with literal expectations
  logic [RW-1:0] tbl [16] = '{
    32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D,
    32'h14131211, 32'h18171615, 32'h1C1B1A19, 32'h201F1E1D,
    32'h24232221, 32'h28272625, 32'h2C2B2A29, 32'h302F2E2D,
    32'h34333231, 32'h38373635, 32'h3C3B3A39, 32'h403F3E3D
  };

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rows(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) begin
      wdata_in  = tbl[i];
      wvalid_in = 1'b1;
      @(negedge clk);
      chk("fill_ready", 64'(wready_out), 64'd1);
      cyc();
    end
    wvalid_in = 1'b0;
    wdata_in  = '0;
  endtask

  task automatic trig_check();
    @(negedge clk);
    chk("trig_high",  64'(trigger_weight), 64'd1);
    chk("trig_ready", 64'(wready_out),     64'd0);
    cyc();
  endtask

  // Drains tile starting at tbl[first]; rows must leave last-written first.
  task automatic drain(input int first, input logic [5:0] pat, input int len);
    int k = 0;
    for (int c = 0; c < len; c++) begin
      load = pat[c];
      @(negedge clk);
      if (c == 0) chk("trig_once", 64'(trigger_weight), 64'd0);
      if (pat[c]) begin
        chk("drain_row",   64'(weight_out),       64'(tbl[first + N - 1 - k]));
        chk("drain_valid", 64'(weight_valid_out), 64'd1);
        k++;
      end else begin
        chk("pause_out",   64'(weight_out),       64'd0);
        chk("pause_valid", 64'(weight_valid_out), 64'd0);
      end
      cyc();
    end
    load = 1'b0;
  endtask

  initial begin
    n_rst     = 1'b0;
    wvalid_in = 1'b0;
    wdata_in  = '0;
    load      = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_ready", 64'(wready_out),       64'd1);
    chk("rst_trig",  64'(trigger_weight),   64'd0);
    chk("rst_out",   64'(weight_out),       64'd0);
    chk("rst_valid", 64'(weight_valid_out), 64'd0);
    chk("rst_err",   64'(load_err),         64'd0);
    cyc();
    n_rst = 1'b1;

    // Tile A: back-to-back fill, continuous drain
    fill_rows(0, 4);
    trig_check();
    drain(0, 6'b001111, 4);
    @(negedge clk);
    chk("a_ready_after", 64'(wready_out), 64'd1);
    cyc();

    // Tile B: paused drain while the host pushes a row that must be refused
    fill_rows(4, 4);
    trig_check();
    wvalid_in = 1'b1;
    wdata_in  = 32'hDEADBEEF;
    drain(4, 6'b111001, 6);
    wvalid_in = 1'b0;
    wdata_in  = '0;
    @(negedge clk);
    chk("b_ready_after", 64'(wready_out), 64'd1);
    chk("b_wr_cnt",      64'(dut.wr_cnt_q), 64'd0);
    cyc();

    // Tile C: premature load with two rows stored
    fill_rows(8, 2);
    load = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("err_pulse", 64'(load_err),         64'd1);
      chk("err_valid", 64'(weight_valid_out), 64'd0);
      chk("err_wrcnt", 64'(dut.wr_cnt_q),     64'd2);
      cyc();
    end
    load = 1'b0;
    fill_rows(10, 2);
    trig_check();
    drain(8, 6'b000011, 2);

    // Reset after two drained rows, then refill with tile D
    n_rst = 1'b0;
    cyc();
    cyc();
    n_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(wready_out),   64'd1);
    chk("mid_rst_wrcnt", 64'(dut.wr_cnt_q), 64'd0);
    cyc();
    fill_rows(12, 4);
    trig_check();
    drain(12, 6'b001111, 4);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
